// File: rtl/rc_tick_if.sv
// Ripple-carry tick interface: tick/config inputs from the upstream side and
// the consumer's count/status outputs.
interface rc_tick_if #(
   parameter int WIDTH = 32
);
   logic             Rc_in;
   logic             Load;
   logic [WIDTH-1:0] PData;
   logic             start;
   logic             stop;
   logic             mode;
   logic             ack;
   logic [WIDTH-1:0] cnt;
   logic             busy;
   logic             irq;
   logic             overrun;

   modport master (
      output Rc_in, Load, PData, start, stop, mode, ack,
      input  cnt, busy, irq, overrun
   );

   modport slave (
      input  Rc_in, Load, PData, start, stop, mode, ack,
      output cnt, busy, irq, overrun
   );
endinterface

// File: rtl/rc_tick_timer.sv
// Consumer end of the Rc interface: counts carry ticks down from a reload
// value and raises a sticky irq (plus overrun) on each expiry.
//
// state | meaning
// IDLE  | not counting; Load also presets cnt, start arms the timer
// RUN   | each Rc_in tick decrements cnt; cnt == 1 with a tick is expiry
module rc_tick_timer #(
   parameter int WIDTH = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   rc_tick_if.slave  bus
);
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ZERO = '0;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             irq_q, irq_d;
   logic             ovr_q, ovr_d;
   logic [WIDTH-1:0] eff_reload;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         reload_q <= '0;
         irq_q    <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
         irq_q    <= irq_d;
         ovr_q    <= ovr_d;
      end
   end

   // A same-cycle Load feeds start directly so software can load-and-go.
   assign eff_reload = bus.Load ? bus.PData : reload_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      reload_d = bus.Load ? bus.PData : reload_q;
      irq_d    = bus.ack ? 1'b0 : irq_q;
      ovr_d    = bus.ack ? 1'b0 : ovr_q;

      unique case (state_q)
         IDLE: begin
            if (bus.Load)
               cnt_d = bus.PData;
            if (!bus.stop && bus.start && (eff_reload != ZERO)) begin
               cnt_d   = eff_reload;
               state_d = RUN;
            end
         end
         RUN: begin
            if (bus.stop) begin
               state_d = IDLE;
            end else if (bus.Rc_in) begin
               if (cnt_q != ONE) begin
                  cnt_d = cnt_q - ONE;
               end else begin
                  // Expiry: set beats a concurrent ack; overrun only if unacked.
                  irq_d = 1'b1;
                  if (irq_q && !bus.ack)
                     ovr_d = 1'b1;
                  if (bus.mode) begin
                     cnt_d = reload_q;
                     if (reload_q == ZERO)
                        state_d = IDLE;
                  end else begin
                     cnt_d   = ZERO;
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.cnt     = cnt_q;
   assign bus.busy    = (state_q == RUN);
   assign bus.irq     = irq_q;
   assign bus.overrun = ovr_q;
endmodule

// File: tb/tb_rc_tick_timer.sv
// Directed self-checking bench for rc_tick_timer.
module tb_rc_tick_timer;
   localparam int WIDTH = 32;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   rc_tick_if #(.WIDTH(WIDTH)) bus ();

   rc_tick_timer #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [WIDTH-1:0] c, input logic b,
                          input logic i, input logic o);
      chk({tag, ".cnt"}, bus.cnt, c);
      chk({tag, ".busy"}, {31'd0, bus.busy}, {31'd0, b});
      chk({tag, ".irq"}, {31'd0, bus.irq}, {31'd0, i});
      chk({tag, ".overrun"}, {31'd0, bus.overrun}, {31'd0, o});
   endtask

   initial begin
      int exp_cnt [12];
      exp_cnt = '{3, 2, 1, 4, 3, 2, 1, 4, 3, 2, 1, 4};
      n_chk  = 0;
      n_fail = 0;
      rst_n     = 1'b0;
      bus.Rc_in = 1'b0;
      bus.Load  = 1'b0;
      bus.PData = '0;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.mode  = 1'b0;
      bus.ack   = 1'b0;
      #2;
      chk_all("reset", 0, 0, 0, 0);
      cyc();
      rst_n = 1'b1;
      cyc();

      // One-shot, reload 3, ticks held high
      bus.Load = 1'b1; bus.PData = 3;
      cyc();
      bus.Load = 1'b0;
      chk_all("os_load", 3, 0, 0, 0);
      bus.start = 1'b1; bus.mode = 1'b0; bus.Rc_in = 1'b1;
      cyc();
      bus.start = 1'b0;
      chk_all("os_start", 3, 1, 0, 0);
      cyc();
      chk_all("os_t1", 2, 1, 0, 0);
      cyc();
      chk_all("os_t2", 1, 1, 0, 0);
      cyc();
      chk_all("os_t3", 0, 0, 1, 0);
      cyc();
      cyc();
      chk_all("os_idle_ticks", 0, 0, 1, 0);
      bus.Rc_in = 1'b0; bus.ack = 1'b1;
      cyc();
      bus.ack = 1'b0;
      chk_all("os_ack", 0, 0, 0, 0);

      // Periodic reload 4, tick every other cycle, no ack
      bus.Load = 1'b1; bus.PData = 4;
      cyc();
      bus.Load = 1'b0;
      bus.start = 1'b1; bus.mode = 1'b1;
      cyc();
      bus.start = 1'b0;
      chk_all("per_start", 4, 1, 0, 0);
      for (int k = 1; k <= 12; k++) begin
         bus.Rc_in = 1'b1;
         cyc();
         bus.Rc_in = 1'b0;
         chk_all($sformatf("per_tick%0d", k), exp_cnt[k-1], 1, k >= 4, k >= 8);
         cyc();
      end

      // Stop, then reload 5 and restart with irq still pending
      bus.stop = 1'b1;
      cyc();
      bus.stop = 1'b0;
      chk_all("per_stop", 4, 0, 1, 1);
      bus.Load = 1'b1; bus.PData = 5;
      cyc();
      bus.Load = 1'b0;
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      chk_all("pre_rst", 5, 1, 1, 1);
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 0, 0, 0, 0);
      cyc();
      rst_n = 1'b1;

      // Start with reload 0 is ignored; load-and-start works
      bus.start = 1'b1;
      cyc();
      chk_all("start_zero", 0, 0, 0, 0);
      bus.Load = 1'b1; bus.PData = 7;
      cyc();
      bus.Load = 1'b0; bus.start = 1'b0;
      chk_all("load_start", 7, 1, 0, 0);

      // Stop wins over a coincident tick
      bus.mode = 1'b0; bus.Rc_in = 1'b1;
      cyc();
      cyc();
      chk("stop_pre.cnt", bus.cnt, 5);
      bus.stop = 1'b1;
      cyc();
      bus.stop = 1'b0;
      chk_all("stop_tick", 5, 0, 0, 0);
      cyc();
      bus.Rc_in = 1'b0;
      chk("idle_tick.cnt", bus.cnt, 5);

      // Restart periodic from reload 7; Load 9 in RUN applies at next reload
      bus.start = 1'b1; bus.mode = 1'b1;
      cyc();
      bus.start = 1'b0;
      chk_all("restart", 7, 1, 0, 0);
      bus.start = 1'b1;
      bus.Load = 1'b1; bus.PData = 9;
      cyc();
      bus.Load = 1'b0; bus.start = 1'b0;
      chk_all("run_load", 7, 1, 0, 0);
      bus.Rc_in = 1'b1;
      repeat (7) cyc();
      chk_all("p7_expire", 9, 1, 1, 0);
      repeat (8) cyc();
      chk_all("p9_t8", 1, 1, 1, 0);
      cyc();
      bus.Rc_in = 1'b0;
      chk_all("p9_expire", 9, 1, 1, 1);

      // Ack coincident with expiry: set wins, no overrun
      bus.stop = 1'b1; bus.ack = 1'b1;
      cyc();
      bus.stop = 1'b0; bus.ack = 1'b0;
      chk_all("clear", 9, 0, 0, 0);
      bus.Load = 1'b1; bus.PData = 2; bus.start = 1'b1;
      cyc();
      bus.Load = 1'b0; bus.start = 1'b0;
      bus.Rc_in = 1'b1;
      cyc();
      cyc();
      chk_all("r2_first", 2, 1, 1, 0);
      cyc();
      bus.ack = 1'b1;
      cyc();
      bus.ack = 1'b0; bus.Rc_in = 1'b0;
      chk_all("ack_expiry", 2, 1, 1, 0);
      bus.stop = 1'b1;
      cyc();
      bus.stop = 1'b0;
      cyc();
      bus.ack = 1'b1;
      cyc();
      bus.ack = 1'b0;
      chk_all("late_ack", 2, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/rc_tick_timer.md
Name: rc_tick_timer

Overview:
- Consumer end of the counter ripple-carry (Rc) interface.
- Counts Rc tick pulses from an upstream loadable counter or prescaler, down from a programmable reload value.
- Raises a sticky interrupt on expiry. Supports one-shot and periodic modes, an ack handshake and overrun detection.
- Sits after the counter in the timer/shift datapath, turning raw carry pulses into software-visible events.

Parameters:
- WIDTH, 32, width of reload register and tick count.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- Rc_in  input  1  tick; one tick counted per clk cycle it is high, no edge detection
- Load  input  1  write PData into the reload register
- PData  input  WIDTH  reload value
- start  input  1  begin counting
- stop  input  1  abort counting
- mode  input  1  0 = one-shot, 1 = periodic; sampled every cycle
- ack  input  1  clears irq and overrun
- cnt  output  WIDTH  remaining ticks (registered)
- busy  output  1  high while in RUN
- irq  output  1  expiry flag, sticky until ack
- overrun  output  1  expiry occurred while irq was still set

Behaviour:
Reset (rst_n low, asynchronous, any state):
- state = IDLE; cnt, reload, busy, irq and overrun all 0.
- Reset mid-count discards all progress.

States: IDLE, RUN. busy = (state == RUN), registered.

Load:
- reload <= PData in any state.
- In IDLE, cnt <= PData as well.
- In RUN, cnt is untouched; the new reload applies at the next periodic reload.

start in IDLE:
- Effective reload value = PData if Load is high in the same cycle, else the reload register.
- If the effective value is 0: start is ignored and the block stays IDLE.
- Otherwise: cnt <= effective value, go to RUN; busy is high next cycle.
- An Rc_in tick in the start cycle is not counted.
- start in RUN is ignored; no restart.

stop:
- Highest priority among stop, start and Rc_in.
- In RUN: go to IDLE next cycle; cnt holds its value; irq and overrun are unaffected; a tick in that cycle is ignored.

Tick in RUN (Rc_in high, no stop):
- cnt > 1: cnt <= cnt - 1.
- cnt == 1 (expiry):
  - irq <= 1.
  - If irq is already 1 and ack is low, overrun <= 1.
  - Periodic mode: cnt <= reload; if reload == 0, go to IDLE with cnt = 0.
  - One-shot mode: cnt <= 0, go to IDLE.
- Reload N gives exactly one irq per N ticks, with no dead tick between periods.
- cnt == 0 never occurs in RUN.

Ticks in IDLE: ignored.

ack:
- Clears irq and overrun next cycle.
- Expiry in the same cycle as ack: irq stays 1 (set wins), overrun is not set.

Latency:
- irq is visible on the edge after the expiring tick is sampled.
- cnt reflects each tick one cycle after it is sampled.

Arithmetic: unsigned, modulo 2^WIDTH. A reload of all-ones is legal and needs 2^WIDTH - 1 ticks to expire.

Test Plan:
- Reset mid-RUN (cnt = 5, irq = 1), then assert rst_n low -> immediately cnt = 0, busy = 0, irq = 0, overrun = 0.
- Load 3, start, mode = 0, Rc_in held high -> cnt goes 3, 2, 1, 0; irq = 1 and busy = 0 after the 3rd tick; no further change with more ticks.
- mode = 1, reload 4, ticks every other cycle for 12 ticks, no ack -> irq set at tick 4; overrun set at tick 8; cnt back at 4 after ticks 4, 8 and 12.
- Periodic reload 2, ack pulsed in the same cycle as the expiring tick -> irq = 1, overrun = 0 next cycle; ack in a later idle cycle -> irq = 0.
- Start with reload 0 -> stays IDLE, busy = 0. Then Load 7 and start in the same cycle -> RUN with cnt = 7.
- RUN cnt = 5, stop and Rc_in together -> IDLE, cnt = 5. Then Load 9 in RUN (after a restart), periodic -> the next period counts 9 ticks.
